router_pkt_fifo: RTL and testbench

Parametrised, packet-aware synchronous FIFO for the router output channels. Successor to the fixed 16x8 channel FIFO. Stores a start-of-packet (header) flag alongside each data word. Tracks packet boundaries on the read side and flags the last word of each packet (parity byte). Adds an occupancy count, an almost-full output, flush on soft reset, and sticky error flags. Sits between the router synchroniser/FSM write side and the per-destination read port.

---
 rtl/router_pkt_fifo.sv | 118 +++++++++++
 tb/tb_router_pkt_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO storing {sop, data}, flagging the last (parity) word of each packet on read.
// Latency: 1 cycle from accepted read to data_out. Backpressure: writes are dropped while full and flag overflow_err; reads are ignored while empty and flag underflow_err.
module router_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_LSB    = 2,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  sop_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_enb,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  sop_out,
    output logic                  eop_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic                  pkt_err
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int LEN_W  = DATA_WIDTH - LEN_LSB;
    localparam int REM_W  = LEN_W + 1;
    localparam int AF_INT = DEPTH - AF_MARGIN;
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = AF_INT[ADDR_WIDTH:0];
    localparam logic [REM_W-1:0]    REM_ONE  = 1;
    localparam logic [REM_W-1:0]    REM_ZERO = 0;

    logic [DATA_WIDTH:0]   mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [REM_W-1:0]      remaining;
    logic [DATA_WIDTH:0]   rd_word;
    logic [LEN_W-1:0]      hdr_len;
    logic                  wr_acc;
    logic                  rd_acc;

    assign count       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                         (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign almost_full = (count >= AF_LEVEL);

    assign wr_acc  = write_enb && !full && !soft_reset && !reset;
    assign rd_acc  = read_enb && !empty && !soft_reset && !reset;
    assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign hdr_len = rd_word[DATA_WIDTH-1:LEN_LSB];

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {sop_in, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            remaining     <= '0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            sop_out       <= 1'b0;
            eop_out       <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            pkt_err       <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            remaining  <= '0;
            data_valid <= 1'b0;
            sop_out    <= 1'b0;
            eop_out    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (write_enb && full) begin
                overflow_err <= 1'b1;
            end
            if (read_enb && empty) begin
                underflow_err <= 1'b1;
            end
            data_valid <= rd_acc;
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word[DATA_WIDTH-1:0];
                sop_out  <= rd_word[DATA_WIDTH];
                if (rd_word[DATA_WIDTH]) begin
                    // A header always restarts tracking, even mid-packet.
                    if (remaining != REM_ZERO) begin
                        pkt_err <= 1'b1;
                    end
                    remaining <= {1'b0, hdr_len} + REM_ONE;
                    eop_out   <= 1'b0;
                end else if (remaining != REM_ZERO) begin
                    remaining <= remaining - REM_ONE;
                    eop_out   <= (remaining == REM_ONE);
                end else begin
                    eop_out <= 1'b0;
                    pkt_err <= 1'b1;
                end
            end else begin
                sop_out <= 1'b0;
                eop_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       sop_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, sop_out, eop_out;
    logic       empty, full, almost_full;
    logic [4:0] count;
    logic       overflow_err, underflow_err, pkt_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [8:0] q[$];
    logic [7:0] m_dout;
    logic       m_dv, m_sop, m_eop, m_ovf, m_unf, m_pkt;
    int         m_rem;

    router_pkt_fifo dut (
        .clk(clk), .reset(reset), .soft_reset(soft_reset),
        .write_enb(write_enb), .sop_in(sop_in), .data_in(data_in),
        .read_enb(read_enb), .data_out(data_out), .data_valid(data_valid),
        .sop_out(sop_out), .eop_out(eop_out), .empty(empty), .full(full),
        .almost_full(almost_full), .count(count),
        .overflow_err(overflow_err), .underflow_err(underflow_err), .pkt_err(pkt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("count",       32'(count),         32'(q.size()));
        check("empty",       32'(empty),         32'(q.size() == 0));
        check("full",        32'(full),          32'(q.size() == 16));
        check("almost_full", 32'(almost_full),   32'(q.size() >= 14));
        check("data_valid",  32'(data_valid),    32'(m_dv));
        check("data_out",    32'(data_out),      32'(m_dout));
        check("sop_out",     32'(sop_out),       32'(m_sop));
        check("eop_out",     32'(eop_out),       32'(m_eop));
        check("overflow",    32'(overflow_err),  32'(m_ovf));
        check("underflow",   32'(underflow_err), 32'(m_unf));
        check("pkt_err",     32'(pkt_err),       32'(m_pkt));
    endtask

    task automatic do_reset();
        reset = 1'b1; write_enb = 1'b0; read_enb = 1'b0; soft_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_dout = 8'h00; m_dv = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0; m_pkt = 1'b0; m_rem = 0;
        check_all();
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic step(input logic w, input logic s, input logic [7:0] d,
                        input logic r, input logic sr);
        logic [8:0] word;
        bit         was_full, was_empty;
        write_enb = w; sop_in = s; data_in = d; read_enb = r; soft_reset = sr;
        if (sr) begin
            q.delete();
            m_rem = 0; m_dv = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
        end else begin
            was_full  = (q.size() == 16);
            was_empty = (q.size() == 0);
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_unf = 1'b1;
            m_dv = r && !was_empty;
            if (m_dv) begin
                word   = q.pop_front();
                m_dout = word[7:0];
                m_sop  = word[8];
                if (word[8]) begin
                    if (m_rem != 0) m_pkt = 1'b1;
                    m_rem = int'(word[7:2]) + 1;
                    m_eop = 1'b0;
                end else if (m_rem != 0) begin
                    m_eop = (m_rem == 1);
                    m_rem--;
                end else begin
                    m_eop = 1'b0;
                    m_pkt = 1'b1;
                end
            end else begin
                m_sop = 1'b0; m_eop = 1'b0;
            end
            if (w && !was_full) q.push_back({s, d});
        end
        @(posedge clk);
        #1;
        write_enb = 1'b0; read_enb = 1'b0; soft_reset = 1'b0; sop_in = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic s, input logic [7:0] d);
        step(1'b1, s, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] pkt2 [5];
        pkt2[0] = 8'h0D; pkt2[1] = 8'hA1; pkt2[2] = 8'hA2; pkt2[3] = 8'hA3; pkt2[4] = 8'h5C;

        do_reset();

        // Basic packet: header len=3, three payload words, parity
        for (int i = 0; i < 5; i++) wr(i == 0, pkt2[i]);
        for (int i = 0; i < 5; i++) begin
            rd();
            check("pkt2_word", 32'(data_out), 32'(pkt2[i]));
            check("pkt2_eop", 32'(eop_out), 32'(i == 4));
        end

        // Zero-length packet, then a truncated packet interrupted by a new header
        do_reset();
        wr(1'b1, 8'h00); wr(1'b0, 8'h00);
        rd(); rd();
        check("len0_eop", 32'(eop_out), 32'd1);
        wr(1'b1, 8'h09); wr(1'b0, 8'h11);
        wr(1'b1, 8'h0D); wr(1'b0, 8'h21); wr(1'b0, 8'h22); wr(1'b0, 8'h23); wr(1'b0, 8'h5A);
        for (int i = 0; i < 7; i++) rd();
        check("restart_eop", 32'(eop_out), 32'd1);
        check("restart_pkt_err", 32'(pkt_err), 32'd1);

        // Payload word with no open packet
        do_reset();
        wr(1'b0, 8'h55); rd();

        // Fill, overflow, read+write when full
        do_reset();
        for (int i = 0; i < 16; i++) wr(1'b0, 8'($urandom));
        wr(1'b0, 8'hEE);
        check("ovf_count", 32'(count), 32'd16);
        step(1'b1, 1'b0, 8'hBB, 1'b1, 1'b0);
        check("full_rw_count", 32'(count), 32'd15);

        // Drain, underflow, write+read when empty
        while (q.size() != 0) rd();
        rd();
        check("underflow_dv", 32'(data_valid), 32'd0);
        step(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
        rd();
        check("empty_rw_data", 32'(data_out), 32'h77);

        // Soft reset flush keeps sticky errors
        for (int i = 0; i < 10; i++) wr(1'b0, 8'($urandom));
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        wr(1'b1, 8'h04); wr(1'b0, 8'h33); rd(); rd();

        // 40 write/read pairs to cross the pointer wrap
        do_reset();
        for (int i = 0; i < 40; i++) begin
            wr(1'b0, 8'(i * 7 + 3));
            rd();
        end

        // Random traffic with occasional flushes
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 3) == 0),
                 8'($urandom), 1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
